// File: rtl/periph_console_responder_if.sv
// periph_console_responder_if: core peripheral request/response port
//   to_peripheral[1:0]       request code (NOP/WRITE/READ/STATUS), driven by the core
//   to_peripheral_data[31:0] request payload
//   to_peripheral_valid      one-cycle request strobe
//   from_peripheral[1:0]     response code, driven by the responder
//   from_peripheral_data     response payload
//   from_peripheral_valid    one-cycle response strobe
interface periph_console_responder_if;
  logic [1:0] to_peripheral;
  logic [31:0] to_peripheral_data;
  logic to_peripheral_valid;
  logic [1:0] from_peripheral;
  logic [31:0] from_peripheral_data;
  logic from_peripheral_valid;
  modport master (
    output to_peripheral, to_peripheral_data, to_peripheral_valid,
    input from_peripheral, from_peripheral_data, from_peripheral_valid
  );
  modport slave (
    input to_peripheral, to_peripheral_data, to_peripheral_valid,
    output from_peripheral, from_peripheral_data, from_peripheral_valid
  );
endinterface

// File: rtl/periph_console_responder.sv
// periph_console_responder: peripheral-port responder backed by TX/RX byte FIFOs
//   clock, reset       system clock, synchronous active-high reset
//   bus                peripheral request/response port (slave side)
//   tx_data/valid/ready TX FIFO head toward the console sink
//   rx_data/valid/ready console source into the RX FIFO
//   dropped_count      saturating count of requests dropped while busy
module periph_console_responder #(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_WORD = 32'hFFFF_FFFF
) (
  input  logic clock,
  input  logic reset,
  periph_console_responder_if.slave bus,
  output logic [7:0] tx_data,
  output logic tx_valid,
  input  logic tx_ready,
  input  logic [7:0] rx_data,
  input  logic rx_valid,
  output logic rx_ready,
  output logic [15:0] dropped_count
);
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int CW = FIFO_ADDR_BITS + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] OP_NOP = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_STATUS = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_TX, WAIT_RX, RESP} state_t;

  state_t state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0] dropped_q, dropped_d;
  logic [1:0] code_q, code_d;
  logic valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [7:0] tx_mem_q [DEPTH], tx_mem_d [DEPTH];
  logic [7:0] rx_mem_q [DEPTH], rx_mem_d [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [FIFO_ADDR_BITS-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_valid = tx_count_q != '0;
  assign tx_data = tx_mem_q[tx_rd_q];
  assign rx_ready = rx_count_q != FULL;
  assign tx_pop = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign dropped_count = dropped_q;
  assign bus.from_peripheral = code_q;
  assign bus.from_peripheral_data = data_q;
  assign bus.from_peripheral_valid = valid_q;

  always_comb begin
    state_d = state_q;
    byte_d = byte_q;
    to_d = to_q;
    dropped_d = dropped_q;
    code_d = OP_NOP;
    valid_d = 1'b0;
    data_d = data_q;
    tx_push = 1'b0;
    rx_pop = 1'b0;
    case (state_q)
      IDLE: if (bus.to_peripheral_valid) begin
        case (bus.to_peripheral)
          OP_WRITE: begin
            byte_d = bus.to_peripheral_data[7:0];
            if (tx_count_q != FULL) begin
              tx_push = 1'b1;
              state_d = RESP;
              valid_d = 1'b1;
              code_d = OP_WRITE;
              data_d = {24'b0, byte_d};
            end else state_d = WAIT_TX;
          end
          OP_READ: if (rx_count_q != '0) begin
            rx_pop = 1'b1;
            state_d = RESP;
            valid_d = 1'b1;
            code_d = OP_READ;
            data_d = {24'b0, rx_mem_q[rx_rd_q]};
          end else begin
            state_d = WAIT_RX;
            to_d = '0;
          end
          OP_STATUS: begin
            state_d = RESP;
            valid_d = 1'b1;
            code_d = OP_STATUS;
            data_d = {16'b0, 8'(rx_count_q), 8'(tx_count_q)};
          end
          default: ;
        endcase
      end
      // A same-cycle sink pop frees the slot, so a full FIFO can still accept the latched byte.
      WAIT_TX: if (tx_count_q != FULL || tx_pop) begin
        tx_push = 1'b1;
        state_d = RESP;
        valid_d = 1'b1;
        code_d = OP_WRITE;
        data_d = {24'b0, byte_q};
      end
      WAIT_RX: if (rx_count_q != '0) begin
        rx_pop = 1'b1;
        state_d = RESP;
        valid_d = 1'b1;
        code_d = OP_READ;
        data_d = {24'b0, rx_mem_q[rx_rd_q]};
      end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        valid_d = 1'b1;
        code_d = OP_READ;
        data_d = TIMEOUT_WORD;
      end else to_d = to_q + TW'(1);
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.to_peripheral_valid && bus.to_peripheral != OP_NOP && dropped_q != '1)
      dropped_d = dropped_q + 16'd1;
  end

  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q] = byte_d;
    if (rx_push) rx_mem_d[rx_wr_q] = rx_data;
    tx_wr_d = tx_wr_q + FIFO_ADDR_BITS'(tx_push);
    tx_rd_d = tx_rd_q + FIFO_ADDR_BITS'(tx_pop);
    rx_wr_d = rx_wr_q + FIFO_ADDR_BITS'(rx_push);
    rx_rd_d = rx_rd_q + FIFO_ADDR_BITS'(rx_pop);
    tx_count_d = tx_count_q + CW'(tx_push) - CW'(tx_pop);
    rx_count_d = rx_count_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q <= '0;
      to_q <= '0;
      dropped_q <= '0;
      code_q <= OP_NOP;
      valid_q <= 1'b0;
      data_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q <= byte_d;
      to_q <= to_d;
      dropped_q <= dropped_d;
      code_q <= code_d;
      valid_q <= valid_d;
      data_q <= data_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  always_ff @(posedge clock) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end
endmodule

// File: tb/tb_periph_console_responder.sv
// tb_periph_console_responder: directed self-checking bench for periph_console_responder
module tb_periph_console_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid, rx_ready;
  logic [15:0] dropped_count;
  int n_checks = 0;
  int n_fail = 0;

  periph_console_responder_if bus();

  periph_console_responder dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .dropped_count(dropped_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic [1:0] code, input logic [31:0] data);
    bus.to_peripheral = code;
    bus.to_peripheral_data = data;
    bus.to_peripheral_valid = 1'b1;
    tick();
    bus.to_peripheral_valid = 1'b0;
    bus.to_peripheral = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.from_peripheral !== 2'b00) begin n_fail++; $display("FAIL reset_code: got %0h expected 0", bus.from_peripheral); end
    n_checks++; if (bus.from_peripheral_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.from_peripheral_data); end
    n_checks++; if (bus.from_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.from_peripheral_valid); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    n_checks++; if (dropped_count !== 16'h0) begin n_fail++; $display("FAIL reset_dropped: got %h expected 0", dropped_count); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    req(2'b01, 32'h0000_0141);
    n_checks++; if (bus.from_peripheral !== 2'b01) begin n_fail++; $display("FAIL write_code: got %0h expected 1", bus.from_peripheral); end
    n_checks++; if (bus.from_peripheral_data !== 32'h41) begin n_fail++; $display("FAIL write_data: got %h expected 00000041", bus.from_peripheral_data); end
    n_checks++; if (bus.from_peripheral_valid !== 1'b1) begin n_fail++; $display("FAIL write_valid: got %b expected 1", bus.from_peripheral_valid); end
    n_checks++; if ({tx_valid, tx_data} !== 9'h141) begin n_fail++; $display("FAIL write_tx_head: got %b/%h expected 1/41", tx_valid, tx_data); end
    tick();
    n_checks++; if ({bus.from_peripheral_valid, bus.from_peripheral} !== 3'b000) begin n_fail++; $display("FAIL write_resp_one_cycle: got valid %b code %0h expected 0/0", bus.from_peripheral_valid, bus.from_peripheral); end
    n_checks++; if (bus.from_peripheral_data !== 32'h41) begin n_fail++; $display("FAIL write_data_hold: got %h expected 00000041", bus.from_peripheral_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL write_tx_drained: got %b expected 0", tx_valid); end
  endtask

  task automatic test_tx_full_wrap();
    for (int i = 0; i < 8; i++) begin
      req(2'b01, 32'(i));
      n_checks++; if ({bus.from_peripheral_valid, bus.from_peripheral_data} !== {1'b1, 32'(i)}) begin n_fail++; $display("FAIL fill_ack%0d: got valid %b data %h expected 1/%h", i, bus.from_peripheral_valid, bus.from_peripheral_data, i); end
      tick();
    end
    req(2'b01, 32'h08);
    tick();
    tick();
    n_checks++; if (bus.from_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL full_wait_no_resp: got %b expected 0", bus.from_peripheral_valid); end
    n_checks++; if ({tx_valid, tx_data} !== 9'h100) begin n_fail++; $display("FAIL full_head: got %b/%h expected 1/00", tx_valid, tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_checks++; if ({bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data} !== {1'b1, 2'b01, 32'h8}) begin n_fail++; $display("FAIL full_late_ack: got %b/%0h/%h expected 1/1/00000008", bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if ({tx_valid, tx_data} !== {1'b1, 8'(i)}) begin n_fail++; $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, tx_valid, tx_data, i); end
      tick();
    end
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_read_wait();
    req(2'b10, 32'h0);
    repeat (9) tick();
    n_checks++; if (bus.from_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL read_wait_no_resp: got %b expected 0", bus.from_peripheral_valid); end
    rx_data = 8'h5A;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_checks++; if (bus.from_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL read_early: got %b expected 0", bus.from_peripheral_valid); end
    tick();
    n_checks++; if ({bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data} !== {1'b1, 2'b10, 32'h5A}) begin n_fail++; $display("FAIL read_data: got %b/%0h/%h expected 1/2/0000005a", bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data); end
    tick();
    req(2'b11, 32'h0);
    n_checks++; if (bus.from_peripheral_data !== 32'h0) begin n_fail++; $display("FAIL read_rx_empty_after: got %h expected 00000000", bus.from_peripheral_data); end
    tick();
  endtask

  task automatic test_timeout();
    int w;
    req(2'b10, 32'h0);
    w = 0;
    while (!bus.from_peripheral_valid && w < 1200) begin
      tick();
      w++;
    end
    n_checks++; if (w !== 1024) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles expected 1024", w); end
    n_checks++; if ({bus.from_peripheral, bus.from_peripheral_data} !== {2'b10, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL timeout_word: got %0h/%h expected 2/ffffffff", bus.from_peripheral, bus.from_peripheral_data); end
    tick();
    req(2'b11, 32'h0);
    n_checks++; if (bus.from_peripheral_data !== 32'h0) begin n_fail++; $display("FAIL timeout_rx_count: got %h expected 00000000", bus.from_peripheral_data); end
    tick();
  endtask

  task automatic test_status();
    logic [7:0] bytes [3];
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      rx_data = bytes[i];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    req(2'b01, 32'hA1);
    tick();
    req(2'b01, 32'hA2);
    tick();
    req(2'b11, 32'h0);
    n_checks++; if ({bus.from_peripheral, bus.from_peripheral_data} !== {2'b11, 32'h0000_0302}) begin n_fail++; $display("FAIL status: got %0h/%h expected 3/00000302", bus.from_peripheral, bus.from_peripheral_data); end
    tick();
    for (int i = 0; i < 3; i++) begin
      req(2'b10, 32'h0);
      n_checks++; if (bus.from_peripheral_data !== {24'b0, bytes[i]}) begin n_fail++; $display("FAIL status_rx_order%0d: got %h expected %h", i, bus.from_peripheral_data, bytes[i]); end
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_drop_and_reset();
    int seen;
    req(2'b10, 32'h0);
    req(2'b01, 32'hAA);
    req(2'b01, 32'hBB);
    req(2'b00, 32'hCC);
    n_checks++; if (bus.from_peripheral_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_resp: got %b expected 0", bus.from_peripheral_valid); end
    n_checks++; if (dropped_count !== 16'd2) begin n_fail++; $display("FAIL drop_count: got %0d expected 2", dropped_count); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drop_tx_unchanged: got %b expected 0", tx_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data} !== {1'b0, 2'b00, 32'h0}) begin n_fail++; $display("FAIL midreset_outputs: got %b/%0h/%h expected 0/0/00000000", bus.from_peripheral_valid, bus.from_peripheral, bus.from_peripheral_data); end
    n_checks++; if ({tx_valid, rx_ready, dropped_count} !== {1'b0, 1'b1, 16'h0}) begin n_fail++; $display("FAIL midreset_side: got tx_valid %b rx_ready %b dropped %0d expected 0/1/0", tx_valid, rx_ready, dropped_count); end
    rx_data = 8'h77;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.from_peripheral_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_late_resp: got %0d responses expected 0", seen); end
  endtask

  initial begin
    bus.to_peripheral = 2'b00;
    bus.to_peripheral_data = 32'h0;
    bus.to_peripheral_valid = 1'b0;
    test_reset();
    test_write();
    test_tx_full_wrap();
    test_read_wait();
    test_timeout();
    test_status();
    test_drop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
